fifo_arbiter: RTL
=================

# fifo_arbiter

Four-to-one arbiter that drains four 6-bit input FIFOs into one downstream FIFO, one word per cycle. It sits between the per-lane FIFO bank and the shared output FIFO. It configures the almost-full and almost-empty thresholds of all FIFOs after reset, then sequences reads and writes by round-robin grant under downstream back-pressure. It flags downstream overflow as a sticky error.

## Interface
Parameters:
- DATA_W, 6: word width.
- NUM_IN, 4: input FIFO count (fixed at 4 in this revision).
- UMB_W, 3: threshold field width.

Ports:
- clk  in  1  single clock, rising edge.
- RESET_L  in  1  asynchronous, active-low reset.
- data_in  in  NUM_IN*DATA_W  input FIFO read data; lane i occupies bits [i*6+5:i*6].
- fifo_empty  in  NUM_IN  empty flags of input FIFOs.
- out_full  in  1  downstream FIFO full.
- out_al_full  in  1  downstream FIFO almost-full.
- umbral_alto_in  in  UMB_W  almost-full threshold requested by the host, sampled in INIT.
- umbral_bajo_in  in  UMB_W  almost-empty threshold requested by the host, sampled in INIT.
- init  in  1  one-cycle pulse that leaves IDLE to start traffic.
- fifo_rd  out  NUM_IN  one-hot pop strobe to the input FIFOs.
- data_out  out  DATA_W  word pushed downstream.
- fifo_wr  out  1  push strobe to the downstream FIFO.
- umbral_alto  out  UMB_W  threshold driven to all FIFOs.
- umbral_bajo  out  UMB_W  threshold driven to all FIFOs.
- grant  out  2  index of the lane currently in flight.
- idle  out  1  high when no word is in flight and all input FIFOs are empty.
- err_fifo  out  1  sticky overflow error.

## Operation
State machine: RESET, INIT, IDLE, ACTIVE, ERROR.
- RESET: entered asynchronously while RESET_L=0. On the first clock after release, go to INIT.
- INIT: register umbral_alto_in and umbral_bajo_in onto the umbral outputs, then go to IDLE. The umbral outputs hold these values until the next reset.
- IDLE: no pops. An init pulse moves the machine to ACTIVE.
- ACTIVE: issue a pop when all of the following hold:
  - at least one fifo_empty bit is 0;
  - out_al_full=0;
  - out_full=0.
- ERROR: entered from any state when fifo_wr=1 and out_full=1 in the same cycle. Sets err_fifo and blocks all further pops. An in-flight word still completes its write. Only reset exits ERROR.

Grant rules:
- Round-robin with pointer last.
- The next grant is the first non-empty lane searching last+1, last+2, ... modulo 4.
- last updates to the granted lane on each pop.
- Reset value of last is 3, so lane 0 wins first.

Arithmetic and flow control:
- The lane index is 2 bits and wraps 3→0.
- At most one word is in flight.
- out_al_full must assert with at least one free slot remaining. The downstream threshold is configured by the umbral outputs, so this holds by construction.

## Timing
Input FIFO contract:
- Registered read: data_in for a lane is valid in the cycle after its fifo_rd.
- fifo_empty reflects a pop in the following cycle.

Pop-to-push latency:
- fifo_rd[g] is asserted in cycle N.
- In cycle N+1: fifo_wr=1, data_out = lane g of data_in (combinational mux on the registered grant), and grant=g.
- Sustained throughput: one word per cycle, with lanes rotating.

Reset values: fifo_rd=0, fifo_wr=0, data_out=0, umbral_alto=0, umbral_bajo=0, grant=0, idle=1, err_fifo=0.

Boundary conditions:
- Single non-empty lane: back-to-back pops are allowed. A lane holding one word is popped once, because empty updates before the next decision.
- out_al_full rising in cycle N: no pop in N. A pop already issued in N-1 still writes in N.
- All lanes empty: fifo_rd=0 and the grant pointer is unchanged.
- Reset mid-transfer: the in-flight word is dropped and all outputs return to reset values immediately.
- init received outside IDLE: ignored.

## Configuration
- FIFO_ARB_STRICT_PRIO_EN defined: fixed priority, lane 0 highest and lane 3 lowest. The last pointer is not implemented.
- FIFO_ARB_STRICT_PRIO_EN undefined (default): round-robin as described above.
- All other behaviour is identical in both builds.

## Structure
- Package fifo_arb_pkg holds:
  - state encoding constants: RESET=0, INIT=1, IDLE=2, ACTIVE=3, ERROR=4, on a 3-bit state;
  - NUM_IN, DATA_W, UMB_W defaults.
- Sub-module rr_grant holds the combinational next-grant search. Inputs: request vector and last. Outputs: valid and 2-bit index. It also contains the strict-priority variant under the macro.

## Test plan
- Reset with RESET_L=0, then release with umbral_alto_in=6 and umbral_bajo_in=2 → INIT, then umbral_alto=6 and umbral_bajo=2 one cycle later; all other outputs at reset values.
- After init, lanes 0–3 each preloaded with 2 words (0x01, 0x02 / 0x11, 0x12 / 0x21, 0x22 / 0x31, 0x32) → downstream receives 0x01, 0x11, 0x21, 0x31, 0x02, 0x12, 0x22, 0x32 on 8 consecutive cycles; idle=1 afterwards.
- Only lane 2 non-empty with 3 words → three consecutive pops of lane 2; grant=2 each write; no fourth pop.
- Hold out_al_full=1 for 5 cycles during traffic → fifo_rd=0 throughout; at most one trailing write; traffic resumes the cycle after deassertion.
- Force out_full=1 while a word is in flight → err_fifo=1 next cycle and stays set; no further fifo_rd until reset.
- Build with FIFO_ARB_STRICT_PRIO_EN, lanes 0 and 3 loaded with 3 words each → all lane-0 words first, then lane 3.

Source files
------------

// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg: shared definitions for the fifo_arbiter slice.
//   - default widths (DATA_W_DEF, NUM_IN_DEF, UMB_W_DEF) and lane index width
//   - state_t: 3-bit controller state encoding
package fifo_arb_pkg;

  localparam int DATA_W_DEF = 6;
  localparam int NUM_IN_DEF = 4;
  localparam int UMB_W_DEF  = 3;
  localparam int LANE_W     = 2;

  typedef enum logic [2:0] {
    RESET  = 3'd0,
    INIT   = 3'd1,
    IDLE   = 3'd2,
    ACTIVE = 3'd3,
    ERROR  = 3'd4
  } state_t;

endpackage

// File: rtl/rr_grant.sv
// rr_grant: combinational next-grant search over the input lanes.
//   req  in  NUM_IN_DEF  request vector (lane not empty)
//   last in  LANE_W      previously granted lane (round-robin build only)
//   vld  out 1           at least one lane requesting
//   idx  out LANE_W      selected lane
// Build option: FIFO_ARB_STRICT_PRIO_EN selects fixed priority (lane 0
// highest); the last pointer does not exist in that build.
module rr_grant
  import fifo_arb_pkg::*;
(
  input  logic [NUM_IN_DEF-1:0] req,
`ifndef FIFO_ARB_STRICT_PRIO_EN
  input  logic [LANE_W-1:0]     last,
`endif
  output logic                  vld,
  output logic [LANE_W-1:0]     idx
);

`ifdef FIFO_ARB_STRICT_PRIO_EN
  // Scan from the lowest-priority lane upwards so lane 0 overwrites last.
  always_comb begin
    vld = |req;
    idx = '0;
    for (int k = NUM_IN_DEF - 1; k >= 0; k--) begin
      if (req[k]) idx = LANE_W'(k);
    end
  end
`else
  // Search last+1, last+2, ... ; the 2-bit add wraps 3 -> 0 naturally.
  always_comb begin
    logic [LANE_W-1:0] cand;
    vld  = 1'b0;
    idx  = last;
    cand = last;
    for (int k = 1; k <= NUM_IN_DEF; k++) begin
      cand = last + LANE_W'(k);
      if (!vld && req[cand]) begin
        vld = 1'b1;
        idx = cand;
      end
    end
  end
`endif

endmodule

// File: rtl/fifo_arbiter.sv
// fifo_arbiter: drains four input FIFOs into one downstream FIFO, one word
// per cycle, and programs the FIFO thresholds after reset.
//   clk, RESET_L            clock, asynchronous active-low reset
//   data_in                 registered read data, lane i at [i*DATA_W +: DATA_W]
//   fifo_empty              input FIFO empty flags
//   out_full, out_al_full   downstream full / almost-full
//   umbral_alto_in/bajo_in  thresholds sampled in INIT
//   init                    start pulse, honoured only in IDLE
//   fifo_rd                 one-hot pop strobe
//   data_out, fifo_wr       downstream push
//   umbral_alto/bajo        thresholds driven to all FIFOs
//   grant                   lane currently in flight
//   idle                    nothing in flight and all inputs empty
//   err_fifo                sticky downstream overflow
// Build option: FIFO_ARB_STRICT_PRIO_EN selects fixed-priority arbitration.
module fifo_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int NUM_IN = NUM_IN_DEF,
  parameter int UMB_W  = UMB_W_DEF
) (
  input  logic                     clk,
  input  logic                     RESET_L,
  input  logic [NUM_IN*DATA_W-1:0] data_in,
  input  logic [NUM_IN-1:0]        fifo_empty,
  input  logic                     out_full,
  input  logic                     out_al_full,
  input  logic [UMB_W-1:0]         umbral_alto_in,
  input  logic [UMB_W-1:0]         umbral_bajo_in,
  input  logic                     init,
  output logic [NUM_IN-1:0]        fifo_rd,
  output logic [DATA_W-1:0]        data_out,
  output logic                     fifo_wr,
  output logic [UMB_W-1:0]         umbral_alto,
  output logic [UMB_W-1:0]         umbral_bajo,
  output logic [LANE_W-1:0]        grant,
  output logic                     idle,
  output logic                     err_fifo
);

  state_t              state;
  state_t              state_nxt;
  logic [NUM_IN-1:0]   req;
  logic                req_vld;
  logic [LANE_W-1:0]   req_idx;
  logic                pop;
  logic                vld_p1;
  logic [LANE_W-1:0]   grant_p1;

  assign req = ~fifo_empty;

`ifdef FIFO_ARB_STRICT_PRIO_EN
  rr_grant u_grant (
    .req (req),
    .vld (req_vld),
    .idx (req_idx)
  );
`else
  logic [LANE_W-1:0] last;

  rr_grant u_grant (
    .req  (req),
    .last (last),
    .vld  (req_vld),
    .idx  (req_idx)
  );

  // Reset to 3 so the first search starts at lane 0.
  always_ff @(posedge clk or negedge RESET_L) begin
    if (!RESET_L)  last <= '1;
    else if (pop)  last <= req_idx;
  end
`endif

  // Pop decision is combinational so a rising out_al_full blocks the same cycle.
  assign pop = (state == ACTIVE) && req_vld && !out_al_full && !out_full;

  always_ff @(posedge clk or negedge RESET_L) begin
    if (!RESET_L) state <= RESET;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RESET:   state_nxt = INIT;
      INIT:    state_nxt = IDLE;
      IDLE:    if (init) state_nxt = ACTIVE;
      ACTIVE:  state_nxt = ACTIVE;
      ERROR:   state_nxt = ERROR;
      default: state_nxt = RESET;
    endcase
    // Overflow wins from any state; only reset leaves ERROR.
    if (vld_p1 && out_full) state_nxt = ERROR;
  end

  // ---- stage p0 -> p1: pop issued, word lands in data_in next cycle ----
  always_ff @(posedge clk or negedge RESET_L) begin
    if (!RESET_L) begin
      vld_p1   <= 1'b0;
      grant_p1 <= '0;
    end else begin
      vld_p1 <= pop;
      if (pop) grant_p1 <= req_idx;
    end
  end

  always_ff @(posedge clk or negedge RESET_L) begin
    if (!RESET_L) begin
      umbral_alto <= '0;
      umbral_bajo <= '0;
    end else if (state == INIT) begin
      umbral_alto <= umbral_alto_in;
      umbral_bajo <= umbral_bajo_in;
    end
  end

  // ---- stage p1: push downstream from the registered grant ----
  always_comb begin
    fifo_rd = '0;
    if (pop) fifo_rd[req_idx] = 1'b1;
    fifo_wr  = vld_p1;
    grant    = grant_p1;
    data_out = '0;
    if (vld_p1) data_out = data_in[int'(grant_p1) * DATA_W +: DATA_W];
    idle     = !vld_p1 && (&fifo_empty);
    err_fifo = (state == ERROR);
  end

endmodule
